// File: rtl/rvh_l1d_alu_arb.sv
// rvh_l1d_alu_arb: shares one combinational L1D ALU among N_REQ requesters.
// Round-robin grant feeds an issue register (S1) that drives the ALU.
// The ALU result is captured into a response register (S2) with valid/ready.
module rvh_l1d_alu_arb #(
   parameter int N_REQ        = 4,
   parameter int XLEN         = 64,
   parameter int ALU_OP_WIDTH = 4,
   parameter int TAG_WIDTH    = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_REQ-1:0]              req_vld_i,
   output logic [N_REQ-1:0]              req_rdy_o,
   input  logic [N_REQ*ALU_OP_WIDTH-1:0] req_opcode_i,
   input  logic [N_REQ-1:0]              req_op_w_i,
   input  logic [N_REQ*XLEN-1:0]         req_operand0_i,
   input  logic [N_REQ*XLEN-1:0]         req_operand1_i,
   input  logic [N_REQ*TAG_WIDTH-1:0]    req_tag_i,
   output logic [ALU_OP_WIDTH-1:0]       alu_opcode_o,
   output logic                          alu_op_w_o,
   output logic [XLEN-1:0]               alu_operand0_o,
   output logic [XLEN-1:0]               alu_operand1_o,
   input  logic [XLEN-1:0]               alu_wb_data_i,
   output logic                          resp_vld_o,
   input  logic                          resp_rdy_i,
   output logic [$clog2(N_REQ)-1:0]      resp_req_id_o,
   output logic [TAG_WIDTH-1:0]          resp_tag_o,
   output logic [XLEN-1:0]               resp_data_o,
   input  logic                          flush_i
);

   localparam int ID_W = $clog2(N_REQ);
   localparam logic [ID_W:0] N_LIM = (ID_W+1)'(N_REQ);

   // Issue register (S1)
   logic                    s1_vld;
   logic [ALU_OP_WIDTH-1:0] s1_opcode;
   logic                    s1_w;
   logic [XLEN-1:0]         s1_op0;
   logic [XLEN-1:0]         s1_op1;
   logic [TAG_WIDTH-1:0]    s1_tag;
   logic [ID_W-1:0]         s1_id;

   // Response register (S2)
   logic                    s2_vld;
   logic [XLEN-1:0]         s2_data;
   logic [TAG_WIDTH-1:0]    s2_tag;
   logic [ID_W-1:0]         s2_id;

   logic [ID_W-1:0]         rr_ptr;
   logic [ID_W-1:0]         grant_id;
   logic                    grant_found;
   logic [ID_W:0]           scan_idx;
   logic [ID_W:0]           next_ptr_ext;
   logic [ID_W-1:0]         next_ptr;
   logic                    s1_adv;
   logic                    s2_adv;
   logic                    accept;

   // Scan requesters starting at rr_ptr and pick the first valid one
   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      scan_idx    = '0;
      for (int k = 0; k < N_REQ; k++) begin
         scan_idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
         if (scan_idx >= N_LIM) begin
            scan_idx = scan_idx - N_LIM;
         end
         if (!grant_found && req_vld_i[scan_idx[ID_W-1:0]]) begin
            grant_found = 1'b1;
            grant_id    = scan_idx[ID_W-1:0];
         end
      end
   end

   // Pipeline advance conditions; nothing is accepted during flush or reset
   always_comb begin
      s2_adv       = ~s2_vld | resp_rdy_i;
      s1_adv       = ~s1_vld | s2_adv;
      accept       = s1_adv & (|req_vld_i) & ~flush_i & ~rst;
      next_ptr_ext = {1'b0, grant_id} + (ID_W+1)'(1);
      next_ptr     = (next_ptr_ext >= N_LIM) ? '0 : next_ptr_ext[ID_W-1:0];
   end

   // One-hot ready toward the granted requester only when it is accepted
   always_comb begin
      req_rdy_o = '0;
      for (int i = 0; i < N_REQ; i++) begin
         req_rdy_o[i] = accept & (grant_id == ID_W'(i));
      end
   end

   // Round-robin pointer moves past the winner on every accept
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (accept) begin
         rr_ptr <= next_ptr;
      end
   end

   // Issue register: load the winner, otherwise drop valid but keep payload stable
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld    <= 1'b0;
         s1_opcode <= '0;
         s1_w      <= 1'b0;
         s1_op0    <= '0;
         s1_op1    <= '0;
         s1_tag    <= '0;
         s1_id     <= '0;
      end else if (flush_i) begin
         s1_vld <= 1'b0;
      end else if (accept) begin
         s1_vld    <= 1'b1;
         s1_opcode <= req_opcode_i[int'(grant_id)*ALU_OP_WIDTH +: ALU_OP_WIDTH];
         s1_w      <= req_op_w_i[grant_id];
         s1_op0    <= req_operand0_i[int'(grant_id)*XLEN +: XLEN];
         s1_op1    <= req_operand1_i[int'(grant_id)*XLEN +: XLEN];
         s1_tag    <= req_tag_i[int'(grant_id)*TAG_WIDTH +: TAG_WIDTH];
         s1_id     <= grant_id;
      end else if (s1_adv) begin
         s1_vld <= 1'b0;
      end
   end

   // Response register: capture the ALU result whenever the consumer side can move
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_vld  <= 1'b0;
         s2_data <= '0;
         s2_tag  <= '0;
         s2_id   <= '0;
      end else if (flush_i) begin
         s2_vld <= 1'b0;
      end else if (s2_adv) begin
         s2_vld <= s1_vld;
         if (s1_vld) begin
            s2_data <= alu_wb_data_i;
            s2_tag  <= s1_tag;
            s2_id   <= s1_id;
         end
      end
   end

   assign alu_opcode_o   = s1_opcode;
   assign alu_op_w_o     = s1_w;
   assign alu_operand0_o = s1_op0;
   assign alu_operand1_o = s1_op1;

   assign resp_vld_o     = s2_vld;
   assign resp_data_o    = s2_data;
   assign resp_tag_o     = s2_tag;
   assign resp_req_id_o  = s2_id;

endmodule

// File: tb/tb_rvh_l1d_alu_arb.sv
// tb_rvh_l1d_alu_arb: randomized scoreboard bench for the shared ALU arbiter.
// A simple ALU model closes the loop; expected responses are queued on accept.
module tb_rvh_l1d_alu_arb;

   localparam int N   = 4;
   localparam int X   = 64;
   localparam int OPW = 4;
   localparam int TW  = 4;

   typedef struct {
      logic [X-1:0]  data;
      logic [1:0]    id;
      logic [TW-1:0] tag;
      int            acc_cycle;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_vld;
   logic [N-1:0]    req_rdy;
   logic [N*OPW-1:0] req_opcode;
   logic [N-1:0]    req_op_w;
   logic [N*X-1:0]  req_operand0;
   logic [N*X-1:0]  req_operand1;
   logic [N*TW-1:0] req_tag;
   logic [OPW-1:0]  alu_opcode;
   logic            alu_op_w;
   logic [X-1:0]    alu_operand0;
   logic [X-1:0]    alu_operand1;
   logic [X-1:0]    alu_wb_data;
   logic            resp_vld;
   logic            resp_rdy;
   logic [1:0]      resp_req_id;
   logic [TW-1:0]   resp_tag;
   logic [X-1:0]    resp_data;
   logic            flush;

   logic [OPW-1:0]  op_a  [N];
   logic            w_a   [N];
   logic [X-1:0]    op0_a [N];
   logic [X-1:0]    op1_a [N];
   logic [TW-1:0]   tag_a [N];

   exp_t  sb_q[$];
   int    checks = 0;
   int    failures = 0;
   int    cycle = 0;
   int    rr_m = 0;
   int    last_not_ready = -10;
   bit    monitor_on = 0;
   bit    reset_check_pending = 0;
   bit    alu_hold_prev = 0;
   bit    prev_stall = 0;
   logic [OPW-1:0] saved_opcode;
   logic           saved_w;
   logic [X-1:0]   saved_op0, saved_op1;
   logic [X-1:0]   saved_rdata;
   logic [TW-1:0]  saved_rtag;
   logic [1:0]     saved_rid;

   // Reference ALU behaviour shared by the loopback and the expected values
   function automatic logic [X-1:0] alu_model(logic [OPW-1:0] op, logic w, logic [X-1:0] a, logic [X-1:0] b);
      logic [X-1:0] r;
      case (op)
         4'd0:    r = a + b;
         4'd1:    r = a - b;
         4'd2:    r = a ^ b;
         4'd3:    r = a & b;
         4'd4:    r = a | b;
         4'd5:    r = a << b[5:0];
         default: r = a;
      endcase
      if (w) r = {{32{r[31]}}, r[31:0]};
      return r;
   endfunction

   // First valid requester at or after the pointer, wrapping around
   function automatic int ref_grant(logic [N-1:0] v, int ptr);
      for (int k = 0; k < N; k++) begin
         if (v[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   always #5 clk = ~clk;

   // Cycle counter used to measure response latency
   always @(posedge clk) cycle <= cycle + 1;

   for (genvar gi = 0; gi < N; gi++) begin : g_pack
      assign req_opcode[gi*OPW +: OPW] = op_a[gi];
      assign req_op_w[gi]              = w_a[gi];
      assign req_operand0[gi*X +: X]   = op0_a[gi];
      assign req_operand1[gi*X +: X]   = op1_a[gi];
      assign req_tag[gi*TW +: TW]      = tag_a[gi];
   end

   assign alu_wb_data = alu_model(alu_opcode, alu_op_w, alu_operand0, alu_operand1);

   rvh_l1d_alu_arb #(.N_REQ(N), .XLEN(X), .ALU_OP_WIDTH(OPW), .TAG_WIDTH(TW)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_vld_i      (req_vld),
      .req_rdy_o      (req_rdy),
      .req_opcode_i   (req_opcode),
      .req_op_w_i     (req_op_w),
      .req_operand0_i (req_operand0),
      .req_operand1_i (req_operand1),
      .req_tag_i      (req_tag),
      .alu_opcode_o   (alu_opcode),
      .alu_op_w_o     (alu_op_w),
      .alu_operand0_o (alu_operand0),
      .alu_operand1_o (alu_operand1),
      .alu_wb_data_i  (alu_wb_data),
      .resp_vld_o     (resp_vld),
      .resp_rdy_i     (resp_rdy),
      .resp_req_id_o  (resp_req_id),
      .resp_tag_o     (resp_tag),
      .resp_data_o    (resp_data),
      .flush_i        (flush)
   );

   task automatic checkOutput(input string name, input logic [X-1:0] act, input logic [X-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   task automatic set_req(input int i, input logic [OPW-1:0] op, input logic w,
                          input logic [X-1:0] a, input logic [X-1:0] b, input logic [TW-1:0] t);
      op_a[i] = op; w_a[i] = w; op0_a[i] = a; op1_a[i] = b; tag_a[i] = t;
      req_vld[i] = 1'b1;
   endtask

   // Randomly raise, hold or drop requests for the requesters in the mask
   task automatic applyStimulus(input logic [N-1:0] mask, input int p_req, input int p_drop);
      for (int i = 0; i < N; i++) begin
         if (!mask[i]) begin
            req_vld[i] = 1'b0;
         end else if (req_vld[i]) begin
            if (int'($urandom_range(0, 99)) < p_drop) req_vld[i] = 1'b0;
         end else if (int'($urandom_range(0, 99)) < p_req) begin
            set_req(i, 4'($urandom_range(0, 6)), 1'($urandom), {$urandom, $urandom},
                    {$urandom, $urandom}, 4'($urandom));
         end
      end
   endtask

   // One clock: check grant against the model, queue expectations, then advance
   task automatic step_cycle();
      bit            acc;
      bit            hold_s1;
      bit            clear_q;
      int            g;
      logic [N-1:0]  exp_rdy;
      logic [N-1:0]  act_rdy;
      exp_t          e;
      @(negedge clk);
      if (reset_check_pending) begin
         checkOutput("rst_resp_vld", 64'(resp_vld), 64'd0);
         checkOutput("rst_resp_data", resp_data, 64'd0);
         checkOutput("rst_resp_tag", 64'(resp_tag), 64'd0);
         checkOutput("rst_resp_id", 64'(resp_req_id), 64'd0);
         checkOutput("rst_alu_opcode", 64'(alu_opcode), 64'd0);
         checkOutput("rst_alu_w", 64'(alu_op_w), 64'd0);
         checkOutput("rst_alu_op0", alu_operand0, 64'd0);
         checkOutput("rst_alu_op1", alu_operand1, 64'd0);
         reset_check_pending = 0;
      end
      if (alu_hold_prev) begin
         checkOutput("hold_alu_opcode", 64'(alu_opcode), 64'(saved_opcode));
         checkOutput("hold_alu_w", 64'(alu_op_w), 64'(saved_w));
         checkOutput("hold_alu_op0", alu_operand0, saved_op0);
         checkOutput("hold_alu_op1", alu_operand1, saved_op1);
      end
      acc     = (req_vld != '0) && !flush && !rst && (sb_q.size() < 2 || resp_rdy);
      hold_s1 = (sb_q.size() == 2) && !resp_rdy && !flush && !rst;
      g       = ref_grant(req_vld, rr_m);
      exp_rdy = acc ? (N'(1) << g) : '0;
      act_rdy = req_rdy;
      checkOutput("grant", 64'(act_rdy), 64'(exp_rdy));
      if (acc) begin
         e.data      = alu_model(op_a[g], w_a[g], op0_a[g], op1_a[g]);
         e.id        = 2'(g);
         e.tag       = tag_a[g];
         e.acc_cycle = cycle;
         sb_q.push_back(e);
         rr_m = (g + 1) % N;
      end
      alu_hold_prev = hold_s1;
      saved_opcode  = alu_opcode;
      saved_w       = alu_op_w;
      saved_op0     = alu_operand0;
      saved_op1     = alu_operand1;
      clear_q       = flush || rst;
      if (rst) begin
         rr_m = 0;
         reset_check_pending = 1;
      end
      @(posedge clk);
      #1;
      if (clear_q) sb_q.delete();
      for (int i = 0; i < N; i++) begin
         if (act_rdy[i]) req_vld[i] = 1'b0;
      end
   endtask

   // Response monitor: pops the scoreboard on every response handshake
   always @(negedge clk) begin
      if (monitor_on) begin
         if (prev_stall) begin
            checkOutput("stall_vld", 64'(resp_vld), 64'd1);
            checkOutput("stall_data", resp_data, saved_rdata);
            checkOutput("stall_tag", 64'(resp_tag), 64'(saved_rtag));
            checkOutput("stall_id", 64'(resp_req_id), 64'(saved_rid));
         end
         if (resp_vld && resp_rdy && !flush && !rst) begin
            if (sb_q.size() == 0) begin
               checkOutput("unexpected_resp", 64'(resp_vld), 64'd0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               checkOutput("resp_data", resp_data, e.data);
               checkOutput("resp_id", 64'(resp_req_id), 64'(e.id));
               checkOutput("resp_tag", 64'(resp_tag), 64'(e.tag));
               if (last_not_ready < e.acc_cycle)
                  checkOutput("resp_latency", 64'(cycle), 64'(e.acc_cycle + 2));
               else
                  checkOutput("resp_not_early", 64'(cycle >= e.acc_cycle + 2), 64'd1);
            end
         end else if (sb_q.size() == 0) begin
            checkOutput("idle_resp_vld", 64'(resp_vld), 64'd0);
         end
         prev_stall  = resp_vld && !resp_rdy && !flush && !rst;
         saved_rdata = resp_data;
         saved_rtag  = resp_tag;
         saved_rid   = resp_req_id;
      end
      if (!resp_rdy) last_not_ready = cycle;
   end

   // Directed scenarios followed by a long randomized run
   initial begin
      rst = 1'b1; flush = 1'b0; resp_rdy = 1'b1; req_vld = '0;
      for (int i = 0; i < N; i++) begin
         op_a[i] = '0; w_a[i] = 1'b0; op0_a[i] = '0; op1_a[i] = '0; tag_a[i] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      monitor_on = 1;
      step_cycle();
      rst = 1'b0;

      $display("[TB] single ADD from requester 2");
      set_req(2, 4'd0, 1'b0, 64'd5, 64'd7, 4'd3);
      repeat (4) step_cycle();

      $display("[TB] round-robin with all requesters valid");
      for (int c = 0; c < 12; c++) begin
         applyStimulus(4'b1111, 100, 0);
         step_cycle();
      end
      req_vld = '0;
      repeat (3) step_cycle();

      $display("[TB] W op from requester 1");
      set_req(1, 4'd0, 1'b1, 64'h7FFF_FFFF, 64'd1, 4'd9);
      repeat (4) step_cycle();

      $display("[TB] backpressure on a requester-0 stream");
      for (int c = 0; c < 12; c++) begin
         applyStimulus(4'b0001, 100, 0);
         resp_rdy = !(c >= 3 && c < 6);
         step_cycle();
      end
      resp_rdy = 1'b1;
      req_vld = '0;
      repeat (3) step_cycle();

      $display("[TB] flush then reset with both stages full");
      for (int pass = 0; pass < 2; pass++) begin
         resp_rdy = 1'b0;
         for (int c = 0; c < 4; c++) begin
            applyStimulus(4'b1111, 100, 0);
            step_cycle();
         end
         if (pass == 0) flush = 1'b1; else rst = 1'b1;
         step_cycle();
         flush = 1'b0; rst = 1'b0; resp_rdy = 1'b1;
         for (int c = 0; c < 4; c++) begin
            applyStimulus(4'b1111, 100, 0);
            step_cycle();
         end
         req_vld = '0;
         repeat (3) step_cycle();
      end

      $display("[TB] lone requester 3");
      for (int c = 0; c < 5; c++) begin
         applyStimulus(4'b1000, 100, 0);
         step_cycle();
      end
      req_vld = '0;
      step_cycle();
      applyStimulus(4'b1111, 100, 0);
      step_cycle();
      req_vld = '0;
      repeat (3) step_cycle();

      $display("[TB] randomized traffic");
      for (int c = 0; c < 3000; c++) begin
         applyStimulus(4'($urandom), 60, 5);
         resp_rdy = (int'($urandom_range(0, 99)) < 70);
         flush    = (int'($urandom_range(0, 99)) < 2);
         rst      = (int'($urandom_range(0, 999)) < 4);
         step_cycle();
      end
      flush = 1'b0; rst = 1'b0; resp_rdy = 1'b1; req_vld = '0;
      repeat (6) step_cycle();
      checkOutput("drain_empty", 64'(sb_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
